// File: rtl/sdf_pkg.sv
// Shared types and helpers for the radix-2^2 SDF stage controller.
package sdf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAD   = 2'd2,
    ST_FLUSH = 2'd3
  } sdf_state_e;

  // Twiddle exponent multiplier k indexed by quadrant q = cnt[m-1:m-2].
  localparam logic [1:0] TW_MULT [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/sdf_delay_sr.sv
// LAT-deep valid/last delay line that advances only while the stage is enabled.
module sdf_delay_sr #(
  parameter int LAT = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid_in,
  input  logic last_in,
  output logic valid_out,
  output logic last_out
);

  logic [LAT-1:0] valid_q, valid_d;
  logic [LAT-1:0] last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    if (en) begin
      valid_d[0] = valid_in;
      last_d[0]  = last_in;
      for (int i = 1; i < LAT; i++) begin
        valid_d[i] = valid_q[i-1];
        last_d[i]  = last_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = valid_q[LAT-1];
  assign last_out  = last_q[LAT-1] & valid_q[LAT-1];

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one radix-2^2 SDF FFT stage (BF1/BF2 selects, twiddle address, output valid).
// Optional zero padding of short frames is enabled by defining SDF_CTRL_ZERO_PAD_EN.
module sdf_stage_ctrl
  import sdf_pkg::*;
#(
  parameter int N   = 64,
  parameter int S   = 64,
  parameter int LAT = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_in,
  output logic                  stage_en,
  output logic                  bf1_sel,
  output logic                  bf2_sel,
  output logic                  bf2_negj,
  output logic [clog2(N)-1:0]   tw_addr,
  output logic                  pad,
  output logic                  enable_out,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_err,
  output logic [1:0]            state_dbg
);

  localparam int AW = clog2(N);
  localparam int M  = clog2(S);
  localparam int FW = clog2(LAT + 1);
  localparam logic [AW-1:0] IDX_MASK   = AW'(S / 4 - 1);
  localparam logic [AW-1:0] NS_STRIDE  = AW'(N / S);
  localparam logic [AW-1:0] CNT_LAST   = AW'(N - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(LAT - 1);

  sdf_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [FW-1:0] flush_q, flush_d;
  logic          in_frame;
  logic          last_in;
  logic [1:0]    quad;
  logic [AW-1:0] tw_k;
  logic [AW-1:0] tw_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  // enable_in seen during a RUN cycle says whether another sample follows this one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flush_d   = '0;
    frame_err = 1'b0;
    cnt_inc   = cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable_in) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (!enable_in) begin
          if (cnt_inc == '0) begin
            state_d = ST_FLUSH;
          end else begin
`ifdef SDF_CTRL_ZERO_PAD_EN
            state_d = ST_PAD;
`else
            state_d   = ST_FLUSH;
            cnt_d     = '0;
            frame_err = 1'b1;
`endif
          end
        end
      end
      ST_PAD: begin
        cnt_d = cnt_inc;
        if (cnt_inc == '0) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        cnt_d = '0;
        if (enable_in) begin
          state_d = ST_RUN;
        end else if (flush_q == FLUSH_LAST) begin
          state_d = ST_IDLE;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_frame = (state_q == ST_RUN) || (state_q == ST_PAD);
    last_in  = in_frame && (cnt_q == CNT_LAST);
    stage_en = (state_q != ST_IDLE);
    busy     = (state_q != ST_IDLE);
`ifdef SDF_CTRL_ZERO_PAD_EN
    pad      = (state_q == ST_PAD);
`else
    pad      = 1'b0;
`endif
    bf1_sel  = cnt_q[M-1];
    bf2_sel  = cnt_q[M-2];
    bf2_negj = cnt_q[M-1] & ~cnt_q[M-2];
    // Twiddle exponent (cnt mod S/4) * k * (N/S), wrapping naturally at log2(N) bits.
    quad     = cnt_q[M-1:M-2];
    tw_k     = AW'(TW_MULT[quad]);
    tw_idx   = cnt_q & IDX_MASK;
    tw_addr  = tw_idx * tw_k * NS_STRIDE;
    state_dbg = state_q;
  end

  sdf_delay_sr #(
    .LAT(LAT)
  ) u_delay_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (stage_en),
    .valid_in (in_frame),
    .last_in  (last_in),
    .valid_out(enable_out),
    .last_out (out_last)
  );

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl at N=64, S=64, LAT=50; cycle numbers are relative to the first RUN cycle.
module tb_sdf_stage_ctrl;

  localparam int N   = 64;
  localparam int S   = 64;
  localparam int LAT = 50;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_in = 1'b0;
  logic       stage_en, bf1_sel, bf2_sel, bf2_negj, pad;
  logic       enable_out, out_last, busy, frame_err;
  logic [5:0] tw_addr;
  logic [1:0] state_dbg;
  logic [14:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  int   rel;
  int   eo_cnt, ferr_cnt, ferr_cyc, pad_cnt, orphan_last;
  logic prev_eo;
  int   eo_starts[$];
  int   last_q[$];

  always #5 clk = ~clk;

  sdf_stage_ctrl #(.N(N), .S(S), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_in (enable_in),
    .stage_en  (stage_en),
    .bf1_sel   (bf1_sel),
    .bf2_sel   (bf2_sel),
    .bf2_negj  (bf2_negj),
    .tw_addr   (tw_addr),
    .pad       (pad),
    .enable_out(enable_out),
    .out_last  (out_last),
    .busy      (busy),
    .frame_err (frame_err),
    .state_dbg (state_dbg)
  );

  assign outs = {stage_en, bf1_sel, bf2_sel, bf2_negj, tw_addr, pad,
                 enable_out, out_last, busy, frame_err};

  task automatic reset_stats();
    rel = -1;
    eo_cnt = 0;
    ferr_cnt = 0;
    ferr_cyc = -1;
    pad_cnt = 0;
    orphan_last = 0;
    prev_eo = 1'b0;
    eo_starts.delete();
    last_q.delete();
  endtask

  // Records output activity for n cycles; entered and left at posedge+1.
  task automatic watch(input int n);
    repeat (n) begin
      #1;
      if (enable_out) begin
        eo_cnt++;
        if (!prev_eo) eo_starts.push_back(rel);
      end
      prev_eo = enable_out;
      if (out_last) begin
        last_q.push_back(rel);
        if (!enable_out) orphan_last++;
      end
      if (frame_err) begin
        ferr_cnt++;
        ferr_cyc = rel;
      end
      if (pad) pad_cnt++;
      rel++;
      @(posedge clk);
      #1;
    end
  endtask

  // One lead cycle with enable_in high, then len RUN cycles; enable_in drops on the last one.
  task automatic drive_frame(input int len);
    enable_in = 1'b1;
    watch(1);
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) enable_in = 1'b0;
      watch(1);
    end
  endtask

  function automatic int first_or(input int idx);
    return (eo_starts.size() > idx) ? eo_starts[idx] : -1;
  endfunction

  function automatic int last_or(input int idx);
    return (last_q.size() > idx) ? last_q[idx] : -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    enable_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (outs !== 15'd0 || state_dbg !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_outputs got outs=%h state=%0d want outs=0 state=0", outs, state_dbg);
    end
    enable_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (state_dbg !== S_IDLE || busy !== 1'b0 || stage_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle got state=%0d busy=%b stage_en=%b want 0 0 0",
               state_dbg, busy, stage_en);
    end
  endtask

  task automatic test_full_frame();
    int   k, exp_tw;
    logic [12:0] got_v, exp_v;
    reset_stats();
    enable_in = 1'b1;
    watch(1);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) enable_in = 1'b0;
      #1;
      k = (i / 16 == 1) ? 2 : (i / 16 == 2) ? 1 : (i / 16 == 3) ? 3 : 0;
      exp_tw = ((i % 16) * k) % 64;
      got_v = {state_dbg, bf1_sel, bf2_sel, bf2_negj, tw_addr, stage_en, pad};
      exp_v = {S_RUN, 1'(i >= 32), 1'((i % 32) >= 16), 1'(i >= 32 && i < 48),
               6'(exp_tw), 1'b1, 1'b0};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL full_frame_sel cnt=%0d got %b want %b", i, got_v, exp_v);
      end
      if (i == 17) begin
        n_cmp++;
        if (tw_addr !== 6'd2) begin
          n_err++;
          $display("FAIL full_frame_tw17 got %0d want 2", tw_addr);
        end
      end
      watch(1);
    end
    n_cmp++;
    if (state_dbg !== S_FLUSH || busy !== 1'b1 || stage_en !== 1'b1 || bf1_sel !== 1'b0) begin
      n_err++;
      $display("FAIL full_frame_flush got state=%0d busy=%b stage_en=%b bf1=%b want 3 1 1 0",
               state_dbg, busy, stage_en, bf1_sel);
    end
    watch(60);
    n_cmp++;
    if (first_or(0) !== 50 || eo_starts.size() !== 1 || eo_cnt !== 64) begin
      n_err++;
      $display("FAIL full_frame_eo got start=%0d runs=%0d count=%0d want 50 1 64",
               first_or(0), eo_starts.size(), eo_cnt);
    end
    n_cmp++;
    if (last_q.size() !== 1 || last_or(0) !== 113 || orphan_last !== 0) begin
      n_err++;
      $display("FAIL full_frame_last got n=%0d at=%0d orphan=%0d want 1 113 0",
               last_q.size(), last_or(0), orphan_last);
    end
    n_cmp++;
    if (ferr_cnt !== 0 || state_dbg !== S_IDLE || busy !== 1'b0) begin
      n_err++;
      $display("FAIL full_frame_end got ferr=%0d state=%0d busy=%b want 0 0 0",
               ferr_cnt, state_dbg, busy);
    end
  endtask

  task automatic test_back_to_back();
    reset_stats();
    enable_in = 1'b1;
    watch(1);
    for (int i = 0; i < 128; i++) begin
      if (i == 127) enable_in = 1'b0;
      #1;
      n_cmp++;
      if (state_dbg !== S_RUN || bf1_sel !== 1'((i % 64) >= 32)) begin
        n_err++;
        $display("FAIL b2b_run i=%0d got state=%0d bf1=%b want 1 %0d",
                 i, state_dbg, bf1_sel, (i % 64) >= 32);
      end
      watch(1);
    end
    watch(60);
    n_cmp++;
    if (first_or(0) !== 50 || eo_starts.size() !== 1 || eo_cnt !== 128) begin
      n_err++;
      $display("FAIL b2b_eo got start=%0d runs=%0d count=%0d want 50 1 128",
               first_or(0), eo_starts.size(), eo_cnt);
    end
    n_cmp++;
    if (last_q.size() !== 2 || last_or(0) !== 113 || last_or(1) !== 177) begin
      n_err++;
      $display("FAIL b2b_last got n=%0d at=%0d,%0d want 2 113,177",
               last_q.size(), last_or(0), last_or(1));
    end
    n_cmp++;
    if (state_dbg !== S_IDLE || ferr_cnt !== 0) begin
      n_err++;
      $display("FAIL b2b_end got state=%0d ferr=%0d want 0 0", state_dbg, ferr_cnt);
    end
  endtask

  task automatic test_short_frame();
    reset_stats();
    drive_frame(40);
    #1;
`ifdef SDF_CTRL_ZERO_PAD_EN
    n_cmp++;
    if (state_dbg !== S_PAD || pad !== 1'b1 || bf1_sel !== 1'b1 || bf2_sel !== 1'b0) begin
      n_err++;
      $display("FAIL short_enter_pad got state=%0d pad=%b bf1=%b bf2=%b want 2 1 1 0",
               state_dbg, pad, bf1_sel, bf2_sel);
    end
    watch(90);
    n_cmp++;
    if (pad_cnt !== 24 || ferr_cnt !== 0) begin
      n_err++;
      $display("FAIL short_pad got pads=%0d ferr=%0d want 24 0", pad_cnt, ferr_cnt);
    end
    n_cmp++;
    if (first_or(0) !== 50 || eo_cnt !== 64 || last_q.size() !== 1 || last_or(0) !== 113) begin
      n_err++;
      $display("FAIL short_pad_out got start=%0d count=%0d nlast=%0d last=%0d want 50 64 1 113",
               first_or(0), eo_cnt, last_q.size(), last_or(0));
    end
`else
    n_cmp++;
    if (state_dbg !== S_FLUSH || pad !== 1'b0 || bf1_sel !== 1'b0 || tw_addr !== 6'd0) begin
      n_err++;
      $display("FAIL short_enter_flush got state=%0d pad=%b bf1=%b tw=%0d want 3 0 0 0",
               state_dbg, pad, bf1_sel, tw_addr);
    end
    watch(90);
    n_cmp++;
    if (ferr_cnt !== 1 || ferr_cyc !== 39 || pad_cnt !== 0) begin
      n_err++;
      $display("FAIL short_ferr got n=%0d at=%0d pads=%0d want 1 39 0", ferr_cnt, ferr_cyc, pad_cnt);
    end
    n_cmp++;
    if (first_or(0) !== 50 || eo_cnt !== 40 || last_q.size() !== 0) begin
      n_err++;
      $display("FAIL short_out got start=%0d count=%0d nlast=%0d want 50 40 0",
               first_or(0), eo_cnt, last_q.size());
    end
`endif
    n_cmp++;
    if (state_dbg !== S_IDLE || busy !== 1'b0) begin
      n_err++;
      $display("FAIL short_end got state=%0d busy=%b want 0 0", state_dbg, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    reset_stats();
    enable_in = 1'b1;
    watch(1);
    watch(20);
    rst_n = 1'b0;
    enable_in = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 15'd0 || state_dbg !== S_IDLE) begin
      n_err++;
      $display("FAIL midreset_outputs got outs=%h state=%0d want 0 0", outs, state_dbg);
    end
    watch(2);
    rst_n = 1'b1;
    watch(60);
    n_cmp++;
    if (eo_cnt !== 0 || ferr_cnt !== 0 || last_q.size() !== 0) begin
      n_err++;
      $display("FAIL midreset_quiet got eo=%0d ferr=%0d nlast=%0d want 0 0 0",
               eo_cnt, ferr_cnt, last_q.size());
    end
    test_full_frame();
  endtask

  task automatic test_flush_restart();
    reset_stats();
    drive_frame(64);
    watch(10);
    #1;
    n_cmp++;
    if (state_dbg !== S_FLUSH) begin
      n_err++;
      $display("FAIL restart_in_flush got state=%0d want 3", state_dbg);
    end
    drive_frame(64);
    watch(70);
    n_cmp++;
    if (eo_starts.size() !== 2 || first_or(0) !== 50 || first_or(1) !== 125 || eo_cnt !== 128) begin
      n_err++;
      $display("FAIL restart_eo got runs=%0d starts=%0d,%0d count=%0d want 2 50,125 128",
               eo_starts.size(), first_or(0), first_or(1), eo_cnt);
    end
    n_cmp++;
    if (first_or(1) - last_or(0) - 1 !== 11) begin
      n_err++;
      $display("FAIL restart_gap got %0d want 11", first_or(1) - last_or(0) - 1);
    end
    n_cmp++;
    if (last_q.size() !== 2 || last_or(0) !== 113 || last_or(1) !== 188 || ferr_cnt !== 0) begin
      n_err++;
      $display("FAIL restart_last got n=%0d at=%0d,%0d ferr=%0d want 2 113,188 0",
               last_q.size(), last_or(0), last_or(1), ferr_cnt);
    end
    n_cmp++;
    if (state_dbg !== S_IDLE) begin
      n_err++;
      $display("FAIL restart_end got state=%0d want 0", state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_short_frame();
    test_reset_mid_frame();
    test_flush_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
